// File: rtl/regwrite_track_queue.sv
// Register-write intent queue: DEPTH-stage valid/rd shift register with stall, flush of the KILL
// youngest stages and a pending-write count; define REGWQ_HAZARD_EN to build the read-port hazard comparators.
module regwrite_track_queue #(
  parameter int DEPTH    = 4,
  parameter int AW       = 5,
  parameter int KILL     = 2,
  parameter int ZERO_REG = 31
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       RegWrt,
  input  logic [AW-1:0]              Rd,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [AW-1:0]              RnA,
  input  logic [AW-1:0]              RnB,
  output logic                       RegWrtO,
  output logic [AW-1:0]              RdO,
  output logic                       hazA,
  output logic                       hazB,
  output logic [$clog2(DEPTH)-1:0]   hazStageA,
  output logic [$clog2(DEPTH)-1:0]   hazStageB,
  output logic [$clog2(DEPTH+1)-1:0] pending
);

  localparam int SW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [AW-1:0]    rd_q [DEPTH];
  logic [AW-1:0]    rd_d [DEPTH];

  // Flush overrides stall: the queue still advances, only the valid bits of young stages are cleared.
  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) rd_d[i] = rd_q[i];
    if (flush || !stall) begin
      v_d[0]  = RegWrt & ~flush;
      rd_d[0] = Rd;
      for (int i = 1; i < DEPTH; i++) begin
        v_d[i]  = v_q[i-1] & ~(flush && (i < KILL));
        rd_d[i] = rd_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
    end else begin
      v_q <= v_d;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= rd_d[i];
    end
  end

  assign RegWrtO = v_q[DEPTH-1];
  assign RdO     = rd_q[DEPTH-1];

  logic [PW-1:0] cnt;
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + PW'(v_q[i]);
  end
  assign pending = cnt;

`ifdef REGWQ_HAZARD_EN
  // Scan oldest to youngest so the youngest match wins the stage index.
  always_comb begin
    hazA      = 1'b0;
    hazB      = 1'b0;
    hazStageA = '0;
    hazStageB = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v_q[i] && (rd_q[i] == RnA) && (RnA != AW'(ZERO_REG))) begin
        hazA      = 1'b1;
        hazStageA = SW'(i);
      end
      if (v_q[i] && (rd_q[i] == RnB) && (RnB != AW'(ZERO_REG))) begin
        hazB      = 1'b1;
        hazStageB = SW'(i);
      end
    end
  end
`else
  logic unused_rn;
  assign unused_rn = ^{RnA, RnB};
  assign hazA      = 1'b0;
  assign hazB      = 1'b0;
  assign hazStageA = '0;
  assign hazStageB = '0;
`endif

endmodule

// File: tb/tb_regwrite_track_queue.sv
// Self-checking bench for regwrite_track_queue (DEPTH=4, KILL=2): directed scenarios plus random traffic vs a stage-list model.
module tb_regwrite_track_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int KILL  = 2;
  localparam int ZR    = 31;
`ifdef REGWQ_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          RegWrt, stall, flush;
  logic [AW-1:0] Rd, RnA, RnB;
  logic          RegWrtO, hazA, hazB;
  logic [AW-1:0] RdO;
  logic [1:0]    hazStageA, hazStageB;
  logic [2:0]    pending;

  int checks = 0;
  int passed = 0;

  // Model: one entry per stage, index 0 youngest.
  bit mv  [DEPTH];
  int mrd [DEPTH];

  regwrite_track_queue #(.DEPTH(DEPTH), .AW(AW), .KILL(KILL), .ZERO_REG(ZR)) dut (
    .clk(clk), .reset(reset), .RegWrt(RegWrt), .Rd(Rd), .stall(stall), .flush(flush),
    .RnA(RnA), .RnB(RnB), .RegWrtO(RegWrtO), .RdO(RdO), .hazA(hazA), .hazB(hazB),
    .hazStageA(hazStageA), .hazStageB(hazStageB), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      mv[i]  = 1'b0;
      mrd[i] = 0;
    end
  endtask

  task automatic drive(input bit rw, input int rd, input bit st, input bit fl);
    RegWrt = rw;
    Rd     = rd[AW-1:0];
    stall  = st;
    flush  = fl;
  endtask

  // Advance one rising edge, update the model from the inputs seen at that edge, settle 1 time unit.
  task automatic cycle();
    @(posedge clk);
    if (!reset) model_clear();
    else if (flush) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        mv[i]  = (i >= KILL) ? mv[i-1] : 1'b0;
        mrd[i] = mrd[i-1];
      end
      mv[0]  = 1'b0;
      mrd[0] = -1;
    end else if (!stall) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        mv[i]  = mv[i-1];
        mrd[i] = mrd[i-1];
      end
      mv[0]  = RegWrt;
      mrd[0] = int'(Rd);
    end
    #1;
  endtask

  function automatic int exp_pend();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(mv[i]);
    return n;
  endfunction

  function automatic void exp_haz(input logic [AW-1:0] rn, output bit hit, output int stg);
    hit = 1'b0;
    stg = 0;
    if (HZ) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!hit && mv[i] && mrd[i] == int'(rn) && int'(rn) != ZR) begin
          hit = 1'b1;
          stg = i;
        end
      end
    end
  endfunction

  task automatic drain();
    drive(0, 0, 0, 0);
    repeat (DEPTH + 1) cycle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1, 12, 0, 0);
    RnA = 5'd12;
    RnB = 5'd12;
    repeat (3) cycle();
    checks++; if (RegWrtO !== 1'b0) $display("FAIL reset_regwrto got=%b exp=0", RegWrtO); else passed++;
    checks++; if (RdO !== '0) $display("FAIL reset_rdo got=%0d exp=0", RdO); else passed++;
    checks++; if (pending !== '0) $display("FAIL reset_pending got=%0d exp=0", pending); else passed++;
    checks++; if ({hazA, hazB, hazStageA, hazStageB} !== 6'b0)
      $display("FAIL reset_haz got=%b%b/%0d/%0d exp=0", hazA, hazB, hazStageA, hazStageB); else passed++;
    drive(0, 0, 0, 0);
    reset = 1'b1;
  endtask

  task automatic test_latency();
    drive(1, 12, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      cycle();
      drive(0, 0, 0, 0);
      checks++; if (RegWrtO !== (k == 4)) $display("FAIL latency_valid edge=%0d got=%b exp=%b", k, RegWrtO, k == 4); else passed++;
      if (k == 4) begin
        checks++; if (RdO !== 5'd12) $display("FAIL latency_rd got=%0d exp=12", RdO); else passed++;
      end
      checks++; if (pending !== ((k <= 4) ? 3'd1 : 3'd0))
        $display("FAIL latency_pending edge=%0d got=%0d exp=%0d", k, pending, (k <= 4) ? 1 : 0); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int peak = 0;
    for (int k = 1; k <= 8; k++) begin
      drive(k <= 4, k + 2, 0, 0);
      cycle();
      if (int'(pending) > peak) peak = int'(pending);
      checks++; if (RegWrtO !== (k >= 4 && k <= 7))
        $display("FAIL b2b_valid edge=%0d got=%b exp=%b", k, RegWrtO, k >= 4 && k <= 7); else passed++;
      if (k >= 4 && k <= 7) begin
        checks++; if (RdO !== AW'(k - 1)) $display("FAIL b2b_rd edge=%0d got=%0d exp=%0d", k, RdO, k - 1); else passed++;
      end
    end
    checks++; if (peak != 4) $display("FAIL b2b_peak got=%0d exp=4", peak); else passed++;
  endtask

  task automatic test_stall();
    for (int k = 1; k <= 8; k++) begin
      drive(k == 1, 7, k == 3 || k == 4, 0);
      cycle();
      checks++; if (RegWrtO !== (k == 6)) $display("FAIL stall_valid edge=%0d got=%b exp=%b", k, RegWrtO, k == 6); else passed++;
      if (k == 6) begin
        checks++; if (RdO !== 5'd7) $display("FAIL stall_rd got=%0d exp=7", RdO); else passed++;
      end
      checks++; if (pending !== ((k <= 6) ? 3'd1 : 3'd0))
        $display("FAIL stall_pending edge=%0d got=%0d exp=%0d", k, pending, (k <= 6) ? 1 : 0); else passed++;
    end
  endtask

  task automatic test_flush();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 5 - k, 0, 0);
      cycle();
    end
    drive(1, 9, 1, 1);
    cycle();
    drive(0, 0, 0, 0);
    checks++; if (RegWrtO !== 1'b1 || RdO !== 5'd3)
      $display("FAIL flush_head got=%b/%0d exp=1/3", RegWrtO, RdO); else passed++;
    checks++; if (pending !== 3'd2) $display("FAIL flush_pending got=%0d exp=2", pending); else passed++;
    cycle();
    checks++; if (RegWrtO !== 1'b1 || RdO !== 5'd2)
      $display("FAIL flush_next got=%b/%0d exp=1/2", RegWrtO, RdO); else passed++;
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++; if (RegWrtO !== 1'b0) $display("FAIL flush_killed edge=%0d got=%b/%0d exp=0", k, RegWrtO, RdO); else passed++;
    end
  endtask

  task automatic test_hazard();
    int seq [4] = '{9, 31, 9, 5};
    for (int k = 0; k < 4; k++) begin
      drive(1, seq[k], 0, 0);
      cycle();
    end
    drive(0, 0, 1, 0);
    RnA = 5'd9; RnB = 5'd31; #1;
    checks++; if (hazA !== HZ || hazStageA !== (HZ ? 2'd1 : 2'd0))
      $display("FAIL haz_a9 got=%b/%0d exp=%b/%0d", hazA, hazStageA, HZ, HZ ? 1 : 0); else passed++;
    checks++; if (hazB !== 1'b0 || hazStageB !== 2'd0)
      $display("FAIL haz_zero_reg got=%b/%0d exp=0/0", hazB, hazStageB); else passed++;
    RnA = 5'd10; RnB = 5'd5; #1;
    checks++; if (hazA !== 1'b0 || hazStageA !== 2'd0)
      $display("FAIL haz_a10 got=%b/%0d exp=0/0", hazA, hazStageA); else passed++;
    checks++; if (hazB !== HZ || hazStageB !== 2'd0)
      $display("FAIL haz_b5 got=%b/%0d exp=%b/0", hazB, hazStageB, HZ); else passed++;
    cycle();
    checks++; if (pending !== 3'd4) $display("FAIL haz_stall_hold got=%0d exp=4", pending); else passed++;
    drain();
  endtask

  task automatic test_random();
    bit hit; int stg;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 2) != 0, ($urandom_range(0, 8) == 0) ? 31 : $urandom_range(0, 7),
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      cycle();
      RnA = AW'(($urandom_range(0, 8) == 0) ? 31 : $urandom_range(0, 7));
      RnB = AW'(($urandom_range(0, 8) == 0) ? 31 : $urandom_range(0, 7));
      #1;
      checks++; if (RegWrtO !== mv[DEPTH-1]) $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, RegWrtO, mv[DEPTH-1]); else passed++;
      if (mv[DEPTH-1]) begin
        checks++; if (int'(RdO) != mrd[DEPTH-1]) $display("FAIL rnd_rd n=%0d got=%0d exp=%0d", n, RdO, mrd[DEPTH-1]); else passed++;
      end
      checks++; if (int'(pending) != exp_pend()) $display("FAIL rnd_pending n=%0d got=%0d exp=%0d", n, pending, exp_pend()); else passed++;
      exp_haz(RnA, hit, stg);
      checks++; if (hazA !== hit || int'(hazStageA) != stg)
        $display("FAIL rnd_hazA n=%0d got=%b/%0d exp=%b/%0d", n, hazA, hazStageA, hit, stg); else passed++;
      exp_haz(RnB, hit, stg);
      checks++; if (hazB !== hit || int'(hazStageB) != stg)
        $display("FAIL rnd_hazB n=%0d got=%b/%0d exp=%b/%0d", n, hazB, hazStageB, hit, stg); else passed++;
    end
    drain();
  endtask

  task automatic test_async_reset();
    for (int k = 1; k <= 3; k++) begin
      drive(1, k, 0, 0);
      cycle();
    end
    drive(0, 0, 0, 0);
    RnA = 5'd2;
    checks++; if (pending !== 3'd3) $display("FAIL arst_pre_pending got=%0d exp=3", pending); else passed++;
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    checks++; if (pending !== 3'd0 || RegWrtO !== 1'b0)
      $display("FAIL arst_immediate got=%0d/%b exp=0/0", pending, RegWrtO); else passed++;
    checks++; if (hazA !== 1'b0 || hazStageA !== 2'd0)
      $display("FAIL arst_haz got=%b/%0d exp=0/0", hazA, hazStageA); else passed++;
    drive(1, 8, 0, 0);
    repeat (2) cycle();
    drive(0, 0, 0, 0);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      checks++; if (RegWrtO !== 1'b0) $display("FAIL arst_no_emit edge=%0d got=%b/%0d exp=0", k, RegWrtO, RdO); else passed++;
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_latency();
    drain();
    test_back_to_back();
    drain();
    test_stall();
    drain();
    test_flush();
    drain();
    test_hazard();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/regwrite_track_queue.md
# regwrite_track_queue

Parametrised successor to the fixed four-stage register-write queue: carries each instruction's register-write intent (RegWrt, Rd) through DEPTH pipeline stages and presents it at the writeback end. It adds pipeline stall, selective flush of the younger stages, a count of pending writes, and two read-port hazard comparators. It sits beside the datapath pipeline of the CPU. The decode stage reads the hazard outputs; the register file consumes RegWrtO/RdO.

## Interface
Parameters:
- DEPTH, 4: number of stages and write latency in cycles; legal range 2..16.
- AW, 5: register address width.
- KILL, 2: number of youngest stages invalidated by flush; legal range 1..DEPTH.
- ZERO_REG, 31: register index that never produces a hazard (XZR).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- RegWrt  in  1  write intent of the instruction entering stage 0.
- Rd  in  AW  destination register of the entering instruction.
- stall  in  1  hold all stages.
- flush  in  1  kill the KILL youngest stages.
- RnA  in  AW  read-port A source register.
- RnB  in  AW  read-port B source register.
- RegWrtO  out  1  valid flag of stage DEPTH-1.
- RdO  out  AW  Rd of stage DEPTH-1.
- hazA  out  1  read-port A matches a pending write.
- hazB  out  1  read-port B matches a pending write.
- hazStageA  out  $clog2(DEPTH)  youngest matching stage index for port A.
- hazStageB  out  $clog2(DEPTH)  youngest matching stage index for port B.
- pending  out  $clog2(DEPTH+1)  number of valid stages.

## Operation
- State: per stage i (0 = youngest, DEPTH-1 = oldest), a valid bit v[i] and an AW-bit rd[i].
- Reset (reset=0, asynchronous):
  - All v[i]=0 and all rd[i]=0.
  - RegWrtO=0, RdO=0, hazA=hazB=0, hazStageA=hazStageB=0, pending=0.
  - Holds for as long as reset is low.
- Normal shift (flush=0, stall=0):
  - Stage 0 takes v=RegWrt and rd=Rd.
  - Stage i takes stage i-1.
  - The stage DEPTH-1 contents are discarded, i.e. consumed by writeback.
- Stall (flush=0, stall=1):
  - Every stage holds its contents and the input is ignored.
  - RegWrtO/RdO repeat, so the consumer must qualify its write with ~stall.
- Flush (flush=1; overrides stall):
  - The queue shifts and the input is not captured.
  - Next v[i]=0 for all i<KILL; next v[i]=v[i-1] for i>=KILL.
  - rd fields shift regardless of valid.
  - With KILL=DEPTH, the queue is empty after the edge.
- RegWrt=0 entries travel as bubbles: v=0, and their rd is carried but never matched.
- Hazard (combinational from registered state only):
  - Match on stage i: v[i] & (rd[i]==RnX) & (RnX!=ZERO_REG).
  - hazX = OR of all matches.
  - hazStageX = lowest matching index, or 0 if there is no match.
- pending = popcount of v[0..DEPTH-1].

## Timing
- Write latency: an input accepted at edge n appears on RegWrtO/RdO after edge n+DEPTH-1. It is therefore visible for the cycle following the DEPTH-th accepting edge, counting edge n, in the absence of stall.
- Each stall cycle adds exactly one cycle of latency.
- All outputs change only on a clk rising edge or on reset assertion.
- No combinational path from any input to RegWrtO, RdO or pending.
- Combinational paths exist only from RnA/RnB to the haz* outputs.
- Reset deassertion: the first capture happens on the first rising edge with reset=1.
- Asserting reset mid-operation discards all in-flight entries and no write is emitted.
- Simultaneous stall and flush: the flush rule applies.

## Configuration
- REGWQ_HAZARD_EN defined: the comparators, hazA/B and hazStageA/B are implemented as specified.
- REGWQ_HAZARD_EN undefined:
  - No comparators are built.
  - hazA=hazB=0 and hazStageA=hazStageB=0 constantly.
  - RnA/RnB are unused.
  - The queue, stall, flush and pending behaviour are unchanged.

## Test plan
- Reset and latency (DEPTH=4): hold reset=0, then release and apply RegWrt=1, Rd=12 for one cycle followed by bubbles -> all outputs 0 during reset; RegWrtO=1, RdO=12 in exactly one cycle, after the 4th edge; pending rises to 1 and returns to 0.
- Back-to-back: Rd=3,4,5,6 with RegWrt=1 on consecutive cycles -> RdO=3,4,5,6 on consecutive cycles, and pending peaks at 4.
- Stall: insert Rd=7, then raise stall for 2 cycles mid-flight -> RdO=7 is delayed by exactly 2 cycles and pending holds at 1 during the stall.
- Flush (KILL=2): fill stages with Rd=1,2,3,4 (4 oldest), then pulse flush together with stall=1 -> after the edge v=0,0,1(rd 2),1(rd 3) and pending=2; Rd=1 is never emitted.
- Hazard: stages hold Rd=9 at index 1 and 3, with RnA=9, RnB=31 and a valid Rd=31 present -> hazA=1, hazStageA=1, hazB=0; RnA=10 -> hazA=0, hazStageA=0.
- Async reset mid-flight: assert reset=0 between edges while pending=3 -> pending, RegWrtO and haz* drop to 0 immediately, and nothing is emitted after release.
